// File: rtl/chacha_pkg.sv
// Shared types, CSR map constants and ChaCha round helpers for chacha_stream.
package chacha_pkg;
  typedef logic [31:0]       Word_t;
  typedef logic [15:0][31:0] State_t;
  typedef logic [3:0]        StateIdx_t;

  localparam logic [5:0] ADDR_INIT_LAST = 6'h0F;
  localparam logic [5:0] ADDR_CONTROL   = 6'h20;
  localparam logic [5:0] ADDR_STATUS    = 6'h21;
  localparam logic [5:0] ADDR_ID        = 6'h22;
  localparam Word_t      CHACHA_ID      = 32'hC4AC0002;
  localparam int         BCOUNT_IDX     = 12;

  function automatic Word_t RotLeft(Word_t x, int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic State_t QRound(State_t s, StateIdx_t ia, StateIdx_t ib,
                                    StateIdx_t ic, StateIdx_t id);
    Word_t a, b, c, d;
    a = s[ia]; b = s[ib]; c = s[ic]; d = s[id];
    a = a + b; d = RotLeft(d ^ a, 16);
    c = c + d; b = RotLeft(b ^ c, 12);
    a = a + b; d = RotLeft(d ^ a, 8);
    c = c + d; b = RotLeft(b ^ c, 7);
    s[ia] = a; s[ib] = b; s[ic] = c; s[id] = d;
    return s;
  endfunction

  function automatic State_t ColumnRound(State_t s);
    s = QRound(s, 4'd0, 4'd4, 4'd8,  4'd12);
    s = QRound(s, 4'd1, 4'd5, 4'd9,  4'd13);
    s = QRound(s, 4'd2, 4'd6, 4'd10, 4'd14);
    s = QRound(s, 4'd3, 4'd7, 4'd11, 4'd15);
    return s;
  endfunction

  function automatic State_t DiagonalRound(State_t s);
    s = QRound(s, 4'd0, 4'd5, 4'd10, 4'd15);
    s = QRound(s, 4'd1, 4'd6, 4'd11, 4'd12);
    s = QRound(s, 4'd2, 4'd7, 4'd8,  4'd13);
    s = QRound(s, 4'd3, 4'd4, 4'd9,  4'd14);
    return s;
  endfunction

  // Word i lands at bits [32i+31:32i].
  function automatic logic [511:0] ToRawState(State_t s);
    return s;
  endfunction
endpackage

// File: rtl/chacha_round_unit.sv
// Combinational ChaCha round step: one or two rounds starting at the given round parity.
module chacha_round_unit import chacha_pkg::*; #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  State_t state_i,
  input  logic   odd_i,
  output State_t state_o
);
  State_t r1;

  always_comb r1 = odd_i ? DiagonalRound(state_i) : ColumnRound(state_i);

  if (ROUNDS_PER_CYCLE == 2) begin : g_two
    assign state_o = odd_i ? ColumnRound(r1) : DiagonalRound(r1);
  end else begin : g_one
    assign state_o = r1;
  end
endmodule

// File: rtl/chacha_stream.sv
// ChaCha keystream generator: CSR-configured multi-pad runs streamed on Avalon-ST.
// Define CHACHA_CSR_READBACK_EN to make INIT[0..15] readable over the CSR port.
module chacha_stream import chacha_pkg::*; #(
  parameter int DOUBLE_ROUNDS    = 10,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int PAD_COUNT_W      = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         csr_write,
  input  logic         csr_read,
  input  logic [5:0]   csr_address,
  input  logic [31:0]  csr_writedata,
  output logic [31:0]  csr_readdata,
  output logic [511:0] st_data,
  output logic         st_valid,
  input  logic         st_ready,
  output logic         irq
);
  localparam int TOTAL = 2 * DOUBLE_ROUNDS;
  localparam int RW    = $clog2(TOTAL);

  typedef enum logic [1:0] {IDLE, ROUND, STALL} fsm_t;

  fsm_t                   state_q;
  State_t                 init_q, work_q, pad_q;
  logic                   st_valid_q, irq_q;
  logic [31:0]            rdata_q;
  logic [RW-1:0]          rnd_q;
  logic [PAD_COUNT_W-1:0] rem_q;

  State_t rnd_out, fin, pad_d, init_inc;
  Word_t  rd_d;
  logic   busy, out_free, last_rnd, ctl_wr, abort, start, init_wr, pad_load, irq_set;

  chacha_round_unit #(.ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)) u_round (
    .state_i (work_q),
    .odd_i   (rnd_q[0]),
    .state_o (rnd_out)
  );

  assign busy     = (state_q != IDLE) || st_valid_q;
  assign out_free = !st_valid_q || st_ready;
  assign last_rnd = (rnd_q == RW'(TOTAL - ROUNDS_PER_CYCLE));
  assign ctl_wr   = csr_write && (csr_address == ADDR_CONTROL);
  assign abort    = ctl_wr && csr_writedata[31];
  assign start    = ctl_wr && !abort && !busy && (csr_writedata[PAD_COUNT_W-1:0] != '0);
  assign init_wr  = csr_write && !busy && (csr_address <= ADDR_INIT_LAST);
  assign fin      = (state_q == STALL) ? work_q : rnd_out;
  assign pad_load = out_free && !abort &&
                    ((state_q == ROUND && last_rnd) || state_q == STALL);
  // Final accept of a run: the FSM has already gone idle with nothing left to do.
  assign irq_set  = st_valid_q && st_ready && (rem_q == '0) && (state_q == IDLE) && !abort;

  always_comb begin
    for (int i = 0; i < 16; i++) pad_d[i] = fin[i] + init_q[i];
    init_inc = init_q;
    init_inc[BCOUNT_IDX] = init_q[BCOUNT_IDX] + 32'd1;
    rd_d = '0;
    case (csr_address)
      ADDR_STATUS: rd_d = {30'd0, irq_q, busy};
      ADDR_ID:     rd_d = CHACHA_ID;
      default:     ;
    endcase
`ifdef CHACHA_CSR_READBACK_EN
    if (csr_address <= ADDR_INIT_LAST) rd_d = init_q[csr_address[3:0]];
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      init_q     <= '0;
      work_q     <= '0;
      pad_q      <= '0;
      st_valid_q <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      rnd_q      <= '0;
      rem_q      <= '0;
    end else begin
      if (csr_read) rdata_q <= rd_d;
      if (st_valid_q && st_ready) st_valid_q <= 1'b0;
      if (csr_write && csr_address == ADDR_STATUS && csr_writedata[1]) irq_q <= 1'b0;
      if (irq_set) irq_q <= 1'b1;
      if (init_wr) init_q[csr_address[3:0]] <= csr_writedata;

      unique case (state_q)
        IDLE: if (start) begin
          work_q  <= init_q;
          rnd_q   <= '0;
          rem_q   <= csr_writedata[PAD_COUNT_W-1:0];
          state_q <= ROUND;
        end
        ROUND: if (!last_rnd) begin
          work_q <= rnd_out;
          rnd_q  <= rnd_q + RW'(ROUNDS_PER_CYCLE);
        end else if (!out_free) begin
          work_q  <= rnd_out;
          state_q <= STALL;
        end
        default: ;
      endcase

      if (pad_load) begin
        pad_q                <= pad_d;
        st_valid_q           <= 1'b1;
        init_q[BCOUNT_IDX]   <= init_inc[BCOUNT_IDX];
        rem_q                <= rem_q - PAD_COUNT_W'(1);
        if (rem_q == PAD_COUNT_W'(1)) begin
          state_q <= IDLE;
        end else begin
          work_q  <= init_inc;
          rnd_q   <= '0;
          state_q <= ROUND;
        end
      end

      if (abort) begin
        state_q    <= IDLE;
        st_valid_q <= 1'b0;
        rem_q      <= '0;
      end
    end
  end

  assign csr_readdata = rdata_q;
  assign st_data      = ToRawState(pad_q);
  assign st_valid     = st_valid_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_chacha_stream.sv
// Randomized self-checking bench for chacha_stream against a behavioural ChaCha20 block model.
module tb_chacha_stream;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         csr_write = 1'b0, csr_read = 1'b0;
  logic [5:0]   csr_address = '0;
  logic [31:0]  csr_writedata = '0;
  logic [31:0]  csr_readdata;
  logic [511:0] st_data;
  logic         st_valid, irq;
  logic         st_ready = 1'b1;

`ifdef CHACHA_CSR_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  int           total = 0, bad = 0;
  logic [31:0]  tb_init [16];
  logic [511:0] beats [$];
  logic [511:0] exp_q [$];
  logic [511:0] held;
  bit           held_v = 1'b0;
  bit           rand_rdy = 1'b0;

  chacha_stream dut (
    .clock(clock), .reset(reset), .csr_write(csr_write), .csr_read(csr_read),
    .csr_address(csr_address), .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Beat monitor: records accepted pads, enforces data hold under backpressure.
  always begin
    @(negedge clock); #1;
    if (!reset) begin
      if (held_v && st_valid) chk("hold", st_data, held);
      held_v = st_valid && !st_ready;
      held   = st_data;
      if (st_valid && st_ready) beats.push_back(st_data);
    end else held_v = 1'b0;
  end

  always @(negedge clock) if (rand_rdy) st_ready = 1'($urandom_range(0, 1));

  function automatic logic [31:0] rol(logic [31:0] v, int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // RFC 8439 block function on the bench copy of INIT with a given block counter.
  function automatic logic [511:0] ref_block(logic [31:0] ctr);
    logic [31:0]  x [16];
    logic [31:0]  in [16];
    logic [511:0] res;
    for (int i = 0; i < 16; i++) in[i] = tb_init[i];
    in[12] = ctr;
    for (int i = 0; i < 16; i++) x[i] = in[i];
    for (int r = 0; r < 10; r++)
      for (int h = 0; h < 2; h++)
        for (int j = 0; j < 4; j++) begin
          int a, b, c, d;
          a = j; b = 4 + (j + h) % 4; c = 8 + (j + 2*h) % 4; d = 12 + (j + 3*h) % 4;
          x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 16);
          x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 12);
          x[a] = x[a] + x[b]; x[d] = rol(x[d] ^ x[a], 8);
          x[c] = x[c] + x[d]; x[b] = rol(x[b] ^ x[c], 7);
        end
    for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + in[i];
    return res;
  endfunction

  task automatic expect_run(int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ref_block(tb_init[12] + 32'(i)));
    tb_init[12] = tb_init[12] + 32'(n);
  endtask

  task automatic csr_wr(logic [5:0] a, logic [31:0] d);
    @(negedge clock);
    csr_write = 1'b1; csr_address = a; csr_writedata = d;
    @(negedge clock);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(logic [5:0] a, output logic [31:0] d);
    @(negedge clock);
    csr_read = 1'b1; csr_address = a;
    @(negedge clock);
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic load_init();
    for (int i = 0; i < 16; i++) csr_wr(6'(i), tb_init[i]);
  endtask

  task automatic rand_init();
    for (int i = 0; i < 16; i++) tb_init[i] = $urandom;
  endtask

  task automatic wait_beats(int n, int budget);
    int c = 0;
    while (beats.size() < n && c < budget) begin
      @(negedge clock); #2; c++;
    end
    if (beats.size() < n) chk("beat_timeout", 512'(beats.size()), 512'(n));
  endtask

  task automatic check_beats(string tag);
    int n;
    chk({tag, "_count"}, 512'(beats.size()), 512'(exp_q.size()));
    n = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, beats[i], exp_q[i]);
    beats.delete();
    exp_q.delete();
  endtask

  task automatic clear_irq();
    csr_wr(6'h21, 32'h2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n, c;
    for (int i = 0; i < 16; i++) tb_init[i] = '0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_valid", 512'(st_valid), 512'(0));
    chk("rst_irq", 512'(irq), 512'(0));
    chk("rst_data", st_data, 512'(0));
    chk("rst_rdata", 512'(csr_readdata), 512'(0));
    reset = 1'b0;
    csr_rd(6'h22, rd); chk("id", 512'(rd), 512'(32'hC4AC0002));
    csr_rd(6'h21, rd); chk("status_idle", 512'(rd), 512'(0));
    csr_rd(6'h30, rd); chk("unmapped", 512'(rd), 512'(0));

    // RFC 8439 2.3.2 vector, latency and irq
    tb_init[0] = 32'h61707865; tb_init[1] = 32'h3320646e;
    tb_init[2] = 32'h79622d32; tb_init[3] = 32'h6b206574;
    for (int k = 0; k < 8; k++)
      tb_init[4+k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    tb_init[12] = 32'h1; tb_init[13] = 32'h09000000;
    tb_init[14] = 32'h4a000000; tb_init[15] = 32'h0;
    load_init();
    expect_run(1);
    csr_wr(6'h20, 32'd1);
    repeat (19) @(negedge clock);
    chk("lat_early", 512'(st_valid), 512'(0));
    @(negedge clock);
    chk("lat_valid", 512'(st_valid), 512'(1));
    chk("rfc_w0", 512'(st_data[31:0]), 512'(32'he4e7f110));
    chk("rfc_w15", 512'(st_data[511:480]), 512'(32'h4e3c50a2));
    wait_beats(1, 100);
    repeat (2) @(negedge clock);
    check_beats("rfc");
    chk("rfc_irq", 512'(irq), 512'(1));
    csr_rd(6'd12, rd); chk("rb_ctr", 512'(rd), 512'(RB ? tb_init[12] : 32'd0));
    csr_rd(6'h21, rd); chk("status_irq", 512'(rd), 512'(2));
    clear_irq();
    chk("irq_clr", 512'(irq), 512'(0));

    // Backpressure: three pads, counters 1..3
    tb_init[12] = 32'h1;
    csr_wr(6'd12, 32'h1);
    st_ready = 1'b0;
    expect_run(3);
    csr_wr(6'h20, 32'd3);
    repeat (25) @(negedge clock);
    held = st_data;
    chk("bp_valid", 512'(st_valid), 512'(1));
    repeat (35) @(negedge clock);
    chk("bp_stable", st_data, exp_q[0]);
    chk("bp_w0", 512'(st_data[31:0]), 512'(32'he4e7f110));
    chk("bp_irq_stall", 512'(irq), 512'(0));
    st_ready = 1'b1;
    c = 0;
    while (beats.size() < 3 && c < 200) begin @(negedge clock); #2; c++; end
    chk("bp_irq_early", 512'(irq), 512'(0));
    repeat (2) @(negedge clock);
    chk("bp_irq", 512'(irq), 512'(1));
    check_beats("bp");
    clear_irq();

    // Counter wrap
    rand_init();
    tb_init[12] = 32'hFFFFFFFF;
    load_init();
    expect_run(2);
    csr_wr(6'h20, 32'd2);
    wait_beats(2, 200);
    repeat (2) @(negedge clock);
    check_beats("wrap");
    csr_rd(6'd13, rd); chk("wrap_w13", 512'(rd), 512'(RB ? tb_init[13] : 32'd0));
    csr_rd(6'd12, rd); chk("wrap_w12", 512'(rd), 512'(RB ? 32'd1 : 32'd0));
    clear_irq();

    // Randomized runs with random backpressure
    rand_rdy = 1'b1;
    for (int t = 0; t < 4; t++) begin
      rand_init();
      n = $urandom_range(1, 3);
      load_init();
      expect_run(n);
      csr_wr(6'h20, {1'b0, 15'($urandom), 16'(n)});
      wait_beats(n, 400 * n);
      repeat (3) @(negedge clock);
      check_beats("rand");
      chk("rand_irq", 512'(irq), 512'(1));
      clear_irq();
    end
    rand_rdy = 1'b0;
    st_ready = 1'b1;

    // Busy protection
    rand_init();
    load_init();
    expect_run(1);
    csr_wr(6'h20, 32'd1);
    repeat (3) @(negedge clock);
    csr_wr(6'h20, 32'd5);
    csr_wr(6'd0, ~tb_init[0]);
    wait_beats(1, 100);
    repeat (60) @(negedge clock);
    check_beats("busy");
    csr_rd(6'd0, rd); chk("busy_init0", 512'(rd), 512'(RB ? tb_init[0] : 32'd0));
    clear_irq();

    // Abort at cycle 7, then confirm the counter was not advanced
    csr_wr(6'h20, 32'd2);
    repeat (5) @(negedge clock);
    csr_wr(6'h20, 32'h80000000);
    repeat (40) @(negedge clock);
    chk("abort_beats", 512'(beats.size()), 512'(0));
    chk("abort_valid", 512'(st_valid), 512'(0));
    chk("abort_irq", 512'(irq), 512'(0));
    csr_rd(6'h21, rd); chk("abort_status", 512'(rd), 512'(0));
    expect_run(1);
    csr_wr(6'h20, 32'd1);
    wait_beats(1, 100);
    repeat (2) @(negedge clock);
    check_beats("post_abort");
    clear_irq();

    // Asynchronous reset mid-run
    st_ready = 1'b0;
    csr_wr(6'h20, 32'd2);
    repeat (30) @(negedge clock);
    chk("mid_valid", 512'(st_valid), 512'(1));
    csr_rd(6'h22, rd);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("arst_valid", 512'(st_valid), 512'(0));
    chk("arst_data", st_data, 512'(0));
    chk("arst_rdata", 512'(csr_readdata), 512'(0));
    chk("arst_irq", 512'(irq), 512'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    st_ready = 1'b1;
    repeat (60) @(negedge clock);
    chk("arst_nobeat", 512'(beats.size()), 512'(0));
    beats.delete();
    for (int i = 0; i < 16; i++) tb_init[i] = '0;
    expect_run(1);
    csr_wr(6'h20, 32'd1);
    wait_beats(1, 100);
    repeat (2) @(negedge clock);
    check_beats("zero_init");
    clear_irq();

    // STATUS clear coincident with final accept: set wins
    rand_init();
    load_init();
    st_ready = 1'b0;
    expect_run(1);
    csr_wr(6'h20, 32'd1);
    c = 0;
    while (!st_valid && c < 100) begin @(negedge clock); c++; end
    chk("coinc_valid", 512'(st_valid), 512'(1));
    @(negedge clock);
    st_ready = 1'b1;
    csr_write = 1'b1; csr_address = 6'h21; csr_writedata = 32'h2;
    @(negedge clock);
    csr_write = 1'b0;
    #2;
    chk("coinc_irq", 512'(irq), 512'(1));
    check_beats("coinc");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
